// File: rtl/mux_seg_display.sv
// Time-multiplexed 7-segment driver: scans N_DIG digits from a per-frame snapshot,
// with leading-zero suppression, per-digit blink, optional hex glyphs and pin polarity.
module mux_seg_display #(
    parameter int N_DIG        = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter bit HEX_EN       = 1'b0,
    parameter bit SEG_ACT_LOW  = 1'b0,
    parameter bit DIG_ACT_LOW  = 1'b1
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [4*N_DIG-1:0] num,
    input  logic [N_DIG-1:0]   dp_in,
    input  logic               blank_en,
    input  logic [N_DIG-1:0]   blink_mask,
    output logic [6:0]         seg,
    output logic               dp,
    output logic [N_DIG-1:0]   an,
    output logic               frame_done
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(N_DIG);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SW-1:0]    SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]    IDX_LAST   = IW'(N_DIG - 1);
    localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [6:0]       SEG_INV    = {7{SEG_ACT_LOW}};
    localparam logic [N_DIG-1:0] AN_INV     = {N_DIG{DIG_ACT_LOW}};

    logic [SW-1:0]      r_scan_cnt;
    logic [IW-1:0]      r_idx;
    logic [BW-1:0]      r_blink_cnt;
    logic               r_phase;
    logic               r_load_pend;
    logic [4*N_DIG-1:0] r_num_sh;
    logic [N_DIG-1:0]   r_dp_sh;
    logic               r_blank_sh;
    logic [N_DIG-1:0]   r_mask_sh;
    logic [6:0]         r_seg;
    logic               r_dp;
    logic [N_DIG-1:0]   r_an;
    logic               r_frame_done;

    logic               w_scan_tc;
    logic               w_frame_end;
    logic               w_load;
    logic [4*N_DIG-1:0] w_num;
    logic [N_DIG-1:0]   w_dp;
    logic               w_blank;
    logic [N_DIG-1:0]   w_mask;
    logic [N_DIG-1:0]   w_zero_from;
    logic [3:0]         w_code;
    logic               w_dp_bit;
    logic               w_blink_bit;
    logic               w_lead_blank;
    logic [N_DIG-1:0]   w_an_raw;
    logic [6:0]         w_seg_raw;
    logic               w_dp_raw;

    function automatic logic [6:0] f_glyph(input logic [3:0] code);
        logic [6:0] g;
        case (code)
            4'h0:    g = 7'b0111111;
            4'h1:    g = 7'b0000110;
            4'h2:    g = 7'b1011011;
            4'h3:    g = 7'b1001111;
            4'h4:    g = 7'b1100110;
            4'h5:    g = 7'b1101101;
            4'h6:    g = 7'b1111101;
            4'h7:    g = 7'b0000111;
            4'h8:    g = 7'b1111111;
            4'h9:    g = 7'b1101111;
            4'hA:    g = HEX_EN ? 7'b1110111 : 7'b0000000;
            4'hB:    g = HEX_EN ? 7'b1111100 : 7'b0000000;
            4'hC:    g = HEX_EN ? 7'b0111001 : 7'b0000000;
            4'hD:    g = HEX_EN ? 7'b1011110 : 7'b0000000;
            4'hE:    g = HEX_EN ? 7'b1111001 : 7'b0000000;
            default: g = HEX_EN ? 7'b1110001 : 7'b0000000;
        endcase
        return g;
    endfunction

    assign w_scan_tc   = (r_scan_cnt == SCAN_LAST);
    assign w_frame_end = w_scan_tc && (r_idx == IDX_LAST);
    assign w_load      = r_load_pend || w_frame_end;

    // While the first snapshot is pending the live inputs stand in for the shadow,
    // so the very first output cycle already shows the data being captured.
    assign w_num   = r_load_pend ? num        : r_num_sh;
    assign w_dp    = r_load_pend ? dp_in      : r_dp_sh;
    assign w_blank = r_load_pend ? blank_en   : r_blank_sh;
    assign w_mask  = r_load_pend ? blink_mask : r_mask_sh;

    always_comb begin
        w_zero_from = '0;
        w_zero_from[N_DIG-1] = (w_num[4*(N_DIG-1) +: 4] == 4'h0);
        for (int k = N_DIG - 2; k >= 0; k--) begin
            w_zero_from[k] = w_zero_from[k+1] && (w_num[4*k +: 4] == 4'h0);
        end
    end

    always_comb begin
        w_code       = 4'h0;
        w_dp_bit     = 1'b0;
        w_blink_bit  = 1'b0;
        w_lead_blank = 1'b0;
        w_an_raw     = '0;
        for (int k = 0; k < N_DIG; k++) begin
            if (r_idx == IW'(k)) begin
                w_code       = w_num[4*k +: 4];
                w_dp_bit     = w_dp[k];
                w_blink_bit  = w_mask[k];
                w_lead_blank = w_blank && (k != 0) && w_zero_from[k];
                w_an_raw[k]  = 1'b1;
            end
        end
    end

    always_comb begin
        w_seg_raw = w_lead_blank ? 7'b0000000 : f_glyph(w_code);
        w_dp_raw  = w_dp_bit;
        if (r_phase && w_blink_bit) begin
            w_seg_raw = 7'b0000000;
            w_dp_raw  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_scan_cnt   <= '0;
            r_idx        <= '0;
            r_blink_cnt  <= '0;
            r_phase      <= 1'b0;
            r_load_pend  <= 1'b1;
            r_num_sh     <= '0;
            r_dp_sh      <= '0;
            r_blank_sh   <= 1'b0;
            r_mask_sh    <= '0;
            r_seg        <= SEG_INV;
            r_dp         <= SEG_ACT_LOW;
            r_an         <= AN_INV;
            r_frame_done <= 1'b0;
        end else begin
            r_scan_cnt <= w_scan_tc ? '0 : r_scan_cnt + 1'b1;
            if (w_scan_tc) begin
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end

            if (w_frame_end) begin
                if (r_blink_cnt == BLINK_LAST) begin
                    r_blink_cnt <= '0;
                    r_phase     <= ~r_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end

            if (w_load) begin
                r_num_sh   <= num;
                r_dp_sh    <= dp_in;
                r_blank_sh <= blank_en;
                r_mask_sh  <= blink_mask;
            end
            r_load_pend <= 1'b0;

            r_seg        <= w_seg_raw ^ SEG_INV;
            r_dp         <= w_dp_raw ^ SEG_ACT_LOW;
            r_an         <= w_an_raw ^ AN_INV;
            // Start of digit 0 in every frame except the one right after reset.
            r_frame_done <= !r_load_pend && (r_idx == '0) && (r_scan_cnt == '0);
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_mux_seg_display.sv
// Bench for mux_seg_display: two polarity/hex variants driven from shared inputs and
// compared each cycle against a time-indexed model of the scanned display.
module tb_mux_seg_display;

    localparam int ND    = 4;
    localparam int SD    = 4;
    localparam int BF    = 2;
    localparam int FRAME = ND * SD;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [15:0] num;
    logic [3:0]  dp_in;
    logic        blank_en;
    logic [3:0]  blink_mask;

    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b, fd_a, fd_b;
    logic [3:0] an_a, an_b;

    always #5 CLK = ~CLK;

    mux_seg_display #(.N_DIG(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF),
                      .HEX_EN(1'b0), .SEG_ACT_LOW(1'b0), .DIG_ACT_LOW(1'b1)) dut_a (
        .CLK(CLK), .RST_N(RST_N), .num(num), .dp_in(dp_in), .blank_en(blank_en),
        .blink_mask(blink_mask), .seg(seg_a), .dp(dp_a), .an(an_a), .frame_done(fd_a));

    mux_seg_display #(.N_DIG(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF),
                      .HEX_EN(1'b1), .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b0)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .num(num), .dp_in(dp_in), .blank_en(blank_en),
        .blink_mask(blink_mask), .seg(seg_b), .dp(dp_b), .an(an_b), .frame_done(fd_b));

    logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int checks = 0;
    int errors = 0;
    int n = 0;               // rising edges since reset release (0 while in reset)
    int fd_seen = 0;

    logic [15:0] s_num;
    logic [3:0]  s_dp, s_mask;
    logic        s_blank;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic take_snap();
        s_num   = num;
        s_dp    = dp_in;
        s_mask  = blink_mask;
        s_blank = blank_en;
    endtask

    task automatic model(input bit hex, input bit sl, input bit dl,
                         output logic [6:0] es, output logic ed,
                         output logic [3:0] ea, output logic ef);
        int dig, f;
        logic [3:0] code;
        logic [15:0] upper;
        bit ph;
        dig   = ((n - 1) / SD) % ND;
        f     = (n - 1) / FRAME;
        ph    = ((f / BF) % 2) == 1;
        upper = s_num >> (4 * dig);
        code  = upper[3:0];
        es    = (code < 4'd10 || hex) ? GLYPH[code] : 7'h00;
        if (s_blank && dig > 0 && upper == 16'h0) es = 7'h00;
        ed = s_dp[dig[1:0]];
        if (ph && s_mask[dig[1:0]]) begin
            es = 7'h00;
            ed = 1'b0;
        end
        ea = 4'b0001 << dig;
        ef = (n > 1) && ((n - 1) % FRAME == 0);
        if (sl) begin
            es = ~es;
            ed = ~ed;
        end
        if (dl) ea = ~ea;
    endtask

    task automatic cycle();
        logic [6:0] es;
        logic       ed, ef;
        logic [3:0] ea;
        @(posedge CLK);
        if (!RST_N) n = 0;
        else begin
            n++;
            if (n == 1) take_snap();
        end
        #1;
        if (n == 0) begin
            chk("a_rst_seg", {1'b0, seg_a}, 8'h00);
            chk("a_rst_dp",  {7'b0, dp_a},  8'h00);
            chk("a_rst_an",  {4'b0, an_a},  8'h0F);
            chk("a_rst_fd",  {7'b0, fd_a},  8'h00);
            chk("b_rst_seg", {1'b0, seg_b}, 8'h7F);
            chk("b_rst_dp",  {7'b0, dp_b},  8'h01);
            chk("b_rst_an",  {4'b0, an_b},  8'h00);
            chk("b_rst_fd",  {7'b0, fd_b},  8'h00);
        end else begin
            model(1'b0, 1'b0, 1'b1, es, ed, ea, ef);
            chk("a_seg", {1'b0, seg_a}, {1'b0, es});
            chk("a_dp",  {7'b0, dp_a},  {7'b0, ed});
            chk("a_an",  {4'b0, an_a},  {4'b0, ea});
            chk("a_fd",  {7'b0, fd_a},  {7'b0, ef});
            model(1'b1, 1'b1, 1'b0, es, ed, ea, ef);
            chk("b_seg", {1'b0, seg_b}, {1'b0, es});
            chk("b_dp",  {7'b0, dp_b},  {7'b0, ed});
            chk("b_an",  {4'b0, an_b},  {4'b0, ea});
            chk("b_fd",  {7'b0, fd_b},  {7'b0, ef});
            if (fd_a === 1'b1) fd_seen++;
            if (n % FRAME == 0) take_snap();
        end
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) cycle();
    endtask

    // Advance until the next edge will be sampled with the scan on digit d, one cycle in.
    task automatic wait_digit(input int d, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 4 * FRAME && !hit; i++) begin
            if (n > 0 && ((n / SD) % ND) == d && (n % SD) == 1) hit = 1'b1;
            else cycle();
        end
        if (!hit) begin
            checks++;
            errors++;
            $error("FAIL %s: observed timeout expected digit %0d", tag, d);
        end
    endtask

    initial begin
        RST_N      = 1'b0;
        num        = 16'h0;
        dp_in      = 4'h0;
        blank_en   = 1'b0;
        blink_mask = 4'h0;
        run(2);

        RST_N = 1'b1;
        num   = 16'h1234;
        run(2 * FRAME);

        wait_digit(2, "snap_wait");
        num = 16'h5678;
        run(2 * FRAME);

        num = 16'h0050; blank_en = 1'b1;
        run(2 * FRAME);
        num = 16'h0000;
        run(2 * FRAME);
        num = 16'h00AF; blank_en = 1'b0;
        run(2 * FRAME);

        num = 16'h1234; blink_mask = 4'b0001; dp_in = 4'b0001;
        run(8 * FRAME);

        for (int i = 0; i < 20 * FRAME; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                num        = 16'($urandom) >> (4 * $urandom_range(0, 4));
                dp_in      = 4'($urandom);
                blink_mask = 4'($urandom);
                blank_en   = 1'($urandom);
            end
            cycle();
        end

        num = 16'h0987; blank_en = 1'b1; blink_mask = 4'h0; dp_in = 4'b0100;
        wait_digit(2, "rst_wait");
        RST_N = 1'b0;
        cycle();
        RST_N = 1'b1;
        fd_seen = 0;
        run(FRAME + 1);
        checks++;
        assert (fd_seen == 1) else begin
            errors++;
            $error("FAIL fd_after_reset: observed %0d expected 1", fd_seen);
        end
        run(FRAME);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
